clip_recorder_module: RTL and testbench
=======================================

Name: clip_recorder_module

Overview:
- Capture-side counterpart to the clip player. Records a triggered stream of 16-bit signed audio samples into the shared clip buffer (CLIP_LEN entries) through a registered write port.
- Tracks the recorded length so the player only reads valid data.
- Sits between the audio input path (I2S RX / synthesis mix) and the clip buffer. Runs on mclk.

Parameters:
- CLIP_LEN, 256, number of 16-bit entries in the clip buffer (power of two, >= 4).
- AW, $clog2(CLIP_LEN), buffer address width (derived, not overridden).

Ports:
- mclk  in  1  master clock (256x sample rate).
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse: clear length and wait for trigger.
- trigger  in  1  level; starts recording while ARMED.
- stop  in  1  one-cycle pulse: end recording, or disarm when ARMED.
- in_sample  in  16  signed input sample (shortint).
- in_valid  in  1  one-cycle strobe, one per sample period.
- wr_en  out  1  buffer write enable.
- wr_addr  out  AW  buffer write address.
- wr_data  out  16  buffer write data (shortint).
- rec_len  out  AW+1  number of valid samples in buffer, 0..CLIP_LEN.
- head_addr  out  AW  next write address (oldest entry once wrapped).
- busy  out  1  high in ARMED or RECORDING.
- done  out  1  level; high in DONE until next arm or rst.

Behaviour:
- Synchronous active-high reset: one clock; reset is synchronous and active-high; ports are mclk and rst.
- Reset values: state IDLE; wr_en=0; wr_addr=0; wr_data=0; rec_len=0; head_addr=0; busy=0; done=0.
- rst asserted mid-recording: takes effect the same edge and aborts; no further wr_en. Buffer contents are not cleared.
- States: IDLE, ARMED, RECORDING, DONE. All outputs are registered.
- IDLE:
  - arm -> ARMED; rec_len:=0, head_addr:=0.
  - trigger, stop and in_valid are ignored.
- ARMED:
  - trigger=1 -> RECORDING.
  - If in_valid=1 on the same cycle as trigger, that sample is recorded (onset capture).
  - stop (no trigger) -> IDLE, done stays 0.
  - trigger and stop on the same cycle: trigger wins, then stop is applied from RECORDING on that edge, giving DONE with rec_len 0 or 1 (1 if in_valid).
  - arm -> re-clears, stays ARMED.
- RECORDING, on each accepted sample (in_valid=1):
  - Next cycle: wr_en=1 for exactly 1 cycle, wr_addr=head_addr (old value), wr_data=in_sample.
  - Latency is 1 mclk from in_valid to wr_en.
  - head_addr increments mod CLIP_LEN.
  - rec_len increments, saturating at CLIP_LEN.
- RECORDING, end conditions:
  - stop -> DONE. A same-cycle in_valid sample is still written.
  - Buffer full (write of index CLIP_LEN-1 issued) -> DONE with rec_len=CLIP_LEN and head_addr wrapped to 0 (non-loop build).
  - arm during RECORDING is ignored.
- DONE:
  - done=1, busy=0, no writes.
  - arm -> ARMED (done:=0, counters cleared). stop and trigger are ignored.
- Zero-length recording (stop before any in_valid): DONE with rec_len=0, head_addr=0.
- in_valid back-to-back on consecutive cycles must be supported: one write per strobe, none dropped.
- busy = state is ARMED or RECORDING. done = state is DONE.

Optional Feature:
- Macro: CLIP_RECORDER_LOOP_EN.
- Defined:
  - Reaching the buffer end does not terminate recording; head_addr wraps to 0 and recording continues, overwriting the oldest samples.
  - rec_len saturates at CLIP_LEN.
  - Only stop (or rst) ends recording.
  - After wrap, head_addr is the address of the oldest valid sample, which is the player's start index.
- Not defined: one-shot. Auto-DONE on the CLIP_LEN-th write, as in Behaviour.

Test Plan:
- Reset/idle: rst 1 cycle, then pulse in_valid x5 without arm -> wr_en never asserts; all outputs at reset values; done=0.
- Basic capture: arm; trigger with same-cycle in_valid sample 0x1234; then samples 0x0001, 0xFFFF; stop -> writes at addr 0,1,2 with data 0x1234, 0x0001, 0xFFFF, each wr_en 1 cycle after in_valid; rec_len=3; head_addr=3; done=1.
- Full buffer, non-loop (CLIP_LEN=8): arm, trigger, 10 back-to-back in_valid -> exactly 8 writes to addr 0..7; DONE after 8th; rec_len=8, head_addr=0; samples 9-10 dropped.
- Loop build (CLIP_LEN=8, CLIP_RECORDER_LOOP_EN): 11 samples, then stop -> 11 writes, addr sequence 0..7,0,1,2; rec_len=8; head_addr=3.
- Control corner cases: stop while ARMED -> IDLE, done=0; stop before any in_valid -> DONE, rec_len=0; arm during RECORDING -> ignored, writes continue; arm in DONE -> done=0, rec_len=0, ARMED.
- Reset mid-record: rst after 3 writes -> next edge all outputs at reset values, no further wr_en, state IDLE.

Source files
------------

// File: rtl/clip_recorder_module.sv
// Clip recorder: captures a triggered stream of 16-bit samples into the clip buffer
// through a registered write port. Define CLIP_RECORDER_LOOP_EN for wrap-around recording.
module clip_recorder_module #(
  parameter int  CLIP_LEN = 256,
  localparam int AW       = $clog2(CLIP_LEN)
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic          arm,
  input  logic          trigger,
  input  logic          stop,
  input  logic [15:0]   in_sample,
  input  logic          in_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic [AW:0]   rec_len,
  output logic [AW-1:0] head_addr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REC, S_DONE} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   full_wr;
  logic   clear;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = in_valid && ((state == S_ARMED && trigger) || state == S_REC);
    clear     = arm && (state == S_IDLE || state == S_DONE || (state == S_ARMED && !trigger));
`ifdef CLIP_RECORDER_LOOP_EN
    full_wr   = 1'b0;
`else
    full_wr   = accept && (head_addr == AW'(CLIP_LEN - 1));
`endif
    unique case (state)
      S_IDLE:  if (arm) state_nxt = S_ARMED;
      S_ARMED: begin
        // Trigger beats stop; a same-cycle stop then closes the take immediately.
        if (trigger)   state_nxt = (stop || full_wr) ? S_DONE : S_REC;
        else if (stop) state_nxt = S_IDLE;
      end
      S_REC:   if (stop || full_wr) state_nxt = S_DONE;
      S_DONE:  if (arm) state_nxt = S_ARMED;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge mclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rec_len   <= '0;
      head_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wr_en <= accept;
      busy  <= (state_nxt == S_ARMED) || (state_nxt == S_REC);
      done  <= (state_nxt == S_DONE);
      if (clear) begin
        rec_len   <= '0;
        head_addr <= '0;
      end else if (accept) begin
        wr_addr   <= head_addr;
        wr_data   <= in_sample;
        // Wraps naturally since CLIP_LEN is a power of two.
        head_addr <= head_addr + AW'(1);
        if (rec_len != (AW+1)'(CLIP_LEN)) rec_len <= rec_len + (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_clip_recorder_module.sv
// Self-checking bench for clip_recorder_module (CLIP_LEN=8): vector table,
// hand-written corner sequences and randomized traffic against a count-based model.
module tb_clip_recorder_module;

  localparam int L  = 8;
  localparam int AW = 3;
`ifdef CLIP_RECORDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          mclk = 1'b0;
  logic          rst, arm, trigger, stop, in_valid;
  logic [15:0]   in_sample;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW:0]   rec_len;
  logic [AW-1:0] head_addr;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  clip_recorder_module #(.CLIP_LEN(L)) dut (
    .mclk(mclk), .rst(rst), .arm(arm), .trigger(trigger), .stop(stop),
    .in_sample(in_sample), .in_valid(in_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rec_len(rec_len), .head_addr(head_addr), .busy(busy), .done(done)
  );

  always #5 mclk = ~mclk;

  // Reference model: a take is described by its mode and the total number of samples
  // captured so far; addresses and lengths follow arithmetically from that count.
  int          m_mode;  // 0 idle, 1 armed, 2 recording, 3 done
  int          m_cnt;
  logic        e_wr;
  logic [15:0] e_data;
  int          e_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_take(input logic [15:0] d);
    e_wr   = 1'b1;
    e_addr = m_cnt % L;
    e_data = d;
    m_cnt++;
    if (!LOOP && m_cnt == L) m_mode = 3;
  endfunction

  function automatic void model_edge(input logic r, a, t, s, v, input logic [15:0] d);
    e_wr = 1'b0;
    if (r) begin
      m_mode = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: if (a) begin m_mode = 1; m_cnt = 0; end
        1: if (t) begin
             m_mode = 2;
             if (v) model_take(d);
             if (s) m_mode = 3;
           end else if (s) m_mode = 0;
           else if (a) m_cnt = 0;
        2: begin
             if (v) model_take(d);
             if (s) m_mode = 3;
           end
        default: if (a) begin m_mode = 1; m_cnt = 0; end
      endcase
    end
  endfunction

  task automatic check_model(input string tag);
    int exp_len;
    exp_len = (m_cnt > L) ? L : m_cnt;
    check({tag, ".wr_en"}, wr_en, e_wr);
    if (e_wr) begin
      check({tag, ".wr_addr"}, wr_addr, e_addr);
      check({tag, ".wr_data"}, wr_data, e_data);
    end
    check({tag, ".rec_len"}, rec_len, exp_len);
    check({tag, ".head_addr"}, head_addr, m_cnt % L);
    check({tag, ".busy"}, busy, m_mode == 1 || m_mode == 2);
    check({tag, ".done"}, done, m_mode == 3);
  endtask

  // One clock: drive inputs, advance the model on the edge, sample 1 time unit later.
  task automatic step(input logic r, a, t, s, v, input logic [15:0] d);
    rst = r; arm = a; trigger = t; stop = s; in_valid = v; in_sample = d;
    @(posedge mclk);
    model_edge(r, a, t, s, v, d);
    #1;
  endtask

  typedef struct {
    logic a, t, s, v;
    logic [15:0] d;
    logic        e_wr;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
    logic [3:0]  e_len;
    logic [2:0]  e_head;
    logic        e_busy, e_done;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int writes;
    int exp_addr;
    //          a  t  s  v  data      wr addr data     len head busy done
    vecs[0]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0}; // arm
    vecs[1]  = '{0, 1, 0, 1, 16'h1234, 1, 0, 16'h1234, 1, 1, 1, 0}; // onset capture
    vecs[2]  = '{0, 0, 0, 1, 16'h0001, 1, 1, 16'h0001, 2, 2, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 16'h5555, 0, 0, 16'h0000, 2, 2, 1, 0};
    vecs[4]  = '{0, 0, 0, 1, 16'hFFFF, 1, 2, 16'hFFFF, 3, 3, 1, 0};
    vecs[5]  = '{0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 3, 3, 0, 1}; // stop -> DONE
    vecs[6]  = '{0, 1, 1, 1, 16'h7777, 0, 0, 16'h0000, 3, 3, 0, 1}; // ignored in DONE
    vecs[7]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0}; // re-arm clears
    vecs[8]  = '{0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0}; // stop while ARMED
    vecs[9]  = '{0, 1, 0, 1, 16'h4444, 0, 0, 16'h0000, 0, 0, 0, 0}; // ignored in IDLE
    vecs[10] = '{1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0};
    vecs[11] = '{0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0}; // recording, no data
    vecs[12] = '{0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1}; // zero-length take
    vecs[13] = '{1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0};
    vecs[14] = '{0, 1, 1, 1, 16'h00AA, 1, 0, 16'h00AA, 1, 1, 0, 1}; // trigger+stop+valid

    // Reset and idle: strobes without arm must not write.
    step(1, 0, 0, 0, 0, 16'h0);
    check("rst.wr_en", wr_en, 0);
    check("rst.wr_addr", wr_addr, 0);
    check("rst.wr_data", wr_data, 0);
    check("rst.rec_len", rec_len, 0);
    check("rst.head_addr", head_addr, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 16'h1111 * i);
      check("idle.wr_en", wr_en, 0);
      check("idle.done", done, 0);
    end

    for (int i = 0; i < 15; i++) begin
      step(0, vecs[i].a, vecs[i].t, vecs[i].s, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d.wr_en", i), wr_en, vecs[i].e_wr);
      if (vecs[i].e_wr) begin
        check($sformatf("vec%0d.wr_addr", i), wr_addr, vecs[i].e_addr);
        check($sformatf("vec%0d.wr_data", i), wr_data, vecs[i].e_data);
      end
      check($sformatf("vec%0d.rec_len", i), rec_len, vecs[i].e_len);
      check($sformatf("vec%0d.head_addr", i), head_addr, vecs[i].e_head);
      check($sformatf("vec%0d.busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d.done", i), done, vecs[i].e_done);
    end

    // Full buffer: 10 back-to-back samples, one-shot keeps only the first L.
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 0, 16'h0);
    writes = 0;
    exp_addr = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, (i == 0), 0, 1, 16'hA000 + 16'(i));
      check_model("full");
      if (wr_en) begin
        check("full.seq_addr", wr_addr, exp_addr % L);
        exp_addr++;
        writes++;
      end
    end
    check("full.writes", writes, LOOP ? 10 : 8);
    check("full.rec_len", rec_len, L);
    check("full.head_addr", head_addr, LOOP ? 2 : 0);
    check("full.done", done, !LOOP);
    step(0, 0, 0, 1, 0, 16'h0);
    check_model("full_stop");

    // Arm during recording is ignored, writes continue.
    step(0, 1, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 1, 16'hB000);
    step(0, 1, 0, 0, 1, 16'hB001);
    check_model("arm_rec");
    check("arm_rec.rec_len", rec_len, 2);
    check("arm_rec.wr_addr", wr_addr, 1);

    // Reset mid-record after 3 writes.
    step(0, 0, 0, 0, 1, 16'hB002);
    step(1, 0, 0, 0, 1, 16'hB003);
    check("rstmid.wr_en", wr_en, 0);
    check("rstmid.rec_len", rec_len, 0);
    check("rstmid.head_addr", head_addr, 0);
    check("rstmid.wr_addr", wr_addr, 0);
    check("rstmid.wr_data", wr_data, 0);
    check("rstmid.busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 1, 16'hC000);
      check("rstmid.after_wr_en", wr_en, 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1, 16'($urandom));
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
